// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with a per-register pending
// (busy) scoreboard. Entry 0 is hardwired to zero and never pending.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, same-cycle
// writes are forwarded to the read ports. When it is not defined, reads see
// only the registered contents.
module reg_file_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*AW-1:0]    rs_addr,
  output logic [NUM_RD*WIDTH-1:0] rs_data,
  output logic [NUM_RD-1:0]       rs_busy,
  input  logic [NUM_WR-1:0]       we,
  input  logic [NUM_WR*AW-1:0]    wa,
  input  logic [NUM_WR*WIDTH-1:0] wd,
  input  logic                    busy_set,
  input  logic [AW-1:0]           busy_addr
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] clr_s;
  logic [DEPTH-1:0] set_s;

  // Decode which busy bits retire (any write) and which become pending (busy_set); entry 0 is masked.
  always_comb begin
    clr_s = {DEPTH{1'b0}};
    set_s = {DEPTH{1'b0}};
    for (int k = 0; k < NUM_WR; k++) begin
      clr_s[wa[k*AW +: AW]] = clr_s[wa[k*AW +: AW]] | we[k];
    end
    set_s[busy_addr] = busy_set;
    clr_s[0] = 1'b0;
    set_s[0] = 1'b0;
  end

  // Busy scoreboard: a new producer (set) overrides a retiring write (clear) to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= (busy_r & ~clr_s) | set_s;
    end
  end

  // Register storage: ports are applied in ascending order so the highest-numbered port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && (wa[k*AW +: AW] != {AW{1'b0}})) begin
          mem_r[wa[k*AW +: AW]] <= wd[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Combinational read ports. Entry 0 is never written and never pending, so it always reads 0 / idle.
  always_comb begin
    rs_data = {NUM_RD*WIDTH{1'b0}};
    rs_busy = {NUM_RD{1'b0}};
    for (int j = 0; j < NUM_RD; j++) begin
      rs_data[j*WIDTH +: WIDTH] = mem_r[rs_addr[j*AW +: AW]];
      rs_busy[j]                = busy_r[rs_addr[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // Forward in write-port order so the later port wins, matching the storage update.
      for (int k = 0; k < NUM_WR; k++) begin
        rs_data[j*WIDTH +: WIDTH] =
          (we[k] && (wa[k*AW +: AW] == rs_addr[j*AW +: AW]) && (rs_addr[j*AW +: AW] != {AW{1'b0}}))
            ? wd[k*WIDTH +: WIDTH] : rs_data[j*WIDTH +: WIDTH];
        rs_busy[j] =
          (we[k] && (wa[k*AW +: AW] == rs_addr[j*AW +: AW]) && (rs_addr[j*AW +: AW] != {AW{1'b0}}))
            ? 1'b0 : rs_busy[j];
      end
`endif
    end
  end

endmodule
